truxton2_snd_writer: RTL and testbench

Sequencing write initiator for the sound block. It accepts byte writes from the main-CPU side into a small FIFO and replays them as correctly timed write cycles on the YM2151 and OKI6295 write ports. Each YM2151 data write is followed by polling the YM2151 busy flag before the next access. It sits between the CPU bus decode and the sound module, driving that module's YM2151_*/OKI_* write inputs.

---
 rtl/truxton2_snd_writer.sv | 184 ++++++++++++++++++
 tb/tb_truxton2_snd_writer.sv | 529 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/truxton2_snd_writer.sv
// Sound-block write sequencer: queues CPU byte writes and replays them as timed
// YM2151 / OKI6295 write cycles, polling the YM2151 busy flag after data writes.
module truxton2_snd_writer #(
  parameter int DEPTH          = 8,
  parameter int YM_STROBE_LEN  = 4,
  parameter int OKI_STROBE_LEN = 128,
  parameter int REC_LEN        = 2,
  parameter int GUARD_LEN      = 64,
  parameter int TIMEOUT        = 16384
) (
  input  logic       CLK96,
  input  logic       RESET96_N,
  input  logic       PAUSE_N,
  input  logic       CPU_WR,
  input  logic       CPU_TGT,
  input  logic       CPU_A0,
  input  logic [7:0] CPU_DIN,
  output logic       CPU_FULL,
  output logic       YM2151_CS,
  output logic       YM2151_WE,
  output logic       YM2151_WR_CMD,
  output logic [7:0] YM2151_DIN,
  input  logic [7:0] YM2151_DOUT,
  output logic       OKI_WE,
  output logic [7:0] OKI_DIN,
  output logic       BUSY,
  output logic       OVF,
  output logic       TMO
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + OKI_STROBE_LEN + GUARD_LEN + YM_STROBE_LEN + REC_LEN + 1) + 1;

  typedef enum logic [2:0] {IDLE, LOAD, STROBE, RECOVER, GUARD, POLL} state_t;

  state_t        state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PW-1:0] count, count_next;
  logic [9:0]    mem [DEPTH];
  logic [9:0]    cur_reg;
  logic          cur_tgt, cur_a0;
  logic [7:0]    cur_data;
  logic          push_ok, pop, tmo_set;

  logic          full_reg, busy_reg, ovf_reg, tmo_reg;
  logic          ym_cs_reg, ym_we_reg, ym_wr_cmd_reg, oki_we_reg;
  logic [7:0]    ym_din_reg, oki_din_reg;

  // Only the busy bit of the status byte is of interest.
  logic          unused_dout;
  assign unused_dout = ^YM2151_DOUT[6:0];

  assign count      = wr_ptr_reg - rd_ptr_reg;
  assign push_ok    = CPU_WR && (count < PW'(DEPTH));
  assign count_next = count + PW'(push_ok) - PW'(pop);
  assign {cur_tgt, cur_a0, cur_data} = cur_reg;

  // Queue storage and the popped-entry register, kept free of reset so the
  // array maps onto plain memory.
  always_ff @(posedge CLK96) begin
    if (push_ok)
      mem[wr_ptr_reg[AW-1:0]] <= {CPU_TGT, CPU_A0, CPU_DIN};
    if (pop)
      cur_reg <= mem[rd_ptr_reg[AW-1:0]];
  end

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    pop        = 1'b0;
    tmo_set    = 1'b0;
    case (state_reg)
      IDLE: begin
        if ((count != '0) && PAUSE_N) begin
          state_next = LOAD;
          pop        = 1'b1;
        end
      end
      LOAD: begin
        state_next = STROBE;
        timer_next = cur_tgt ? TW'(OKI_STROBE_LEN - 1) : TW'(YM_STROBE_LEN - 1);
      end
      STROBE: begin
        if (timer_reg == '0) begin
          state_next = RECOVER;
          timer_next = TW'(REC_LEN - 1);
        end else begin
          timer_next = timer_reg - TW'(1);
        end
      end
      RECOVER: begin
        if (timer_reg == '0) begin
          if (!cur_tgt && cur_a0) begin
            state_next = GUARD;
            timer_next = TW'(GUARD_LEN - 1);
          end else begin
            state_next = IDLE;
          end
        end else begin
          timer_next = timer_reg - TW'(1);
        end
      end
      GUARD: begin
        if (timer_reg == '0) begin
          state_next = POLL;
          timer_next = TW'(TIMEOUT - 1);
        end else begin
          timer_next = timer_reg - TW'(1);
        end
      end
      POLL: begin
        if (!YM2151_DOUT[7]) begin
          state_next = IDLE;
        end else if (timer_reg == '0) begin
          state_next = IDLE;
          tmo_set    = 1'b1;
        end else begin
          timer_next = timer_reg - TW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK96 or negedge RESET96_N) begin
    if (!RESET96_N) begin
      state_reg     <= IDLE;
      timer_reg     <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      full_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
      tmo_reg       <= 1'b0;
      ym_cs_reg     <= 1'b0;
      ym_we_reg     <= 1'b1;
      ym_wr_cmd_reg <= 1'b0;
      ym_din_reg    <= '0;
      oki_we_reg    <= 1'b1;
      oki_din_reg   <= '0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      if (push_ok)
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      // FULL follows the occupancy one cycle late, so it lags both fill and free.
      full_reg <= (count == PW'(DEPTH));
      busy_reg <= (count_next != '0) || (state_next != IDLE);
      if (CPU_WR && !push_ok)
        ovf_reg <= 1'b1;
      if (tmo_set)
        tmo_reg <= 1'b1;
      if (state_reg == LOAD) begin
        if (cur_tgt) begin
          oki_din_reg <= cur_data;
        end else begin
          ym_din_reg    <= cur_data;
          ym_wr_cmd_reg <= cur_a0;
          ym_cs_reg     <= 1'b1;
        end
      end
      if ((state_reg == RECOVER) && (state_next != RECOVER))
        ym_cs_reg <= 1'b0;
      ym_we_reg  <= !((state_next == STROBE) && !cur_tgt);
      oki_we_reg <= !((state_next == STROBE) && cur_tgt);
    end
  end

  assign CPU_FULL      = full_reg;
  assign BUSY          = busy_reg;
  assign OVF           = ovf_reg;
  assign TMO           = tmo_reg;
  assign YM2151_CS     = ym_cs_reg;
  assign YM2151_WE     = ym_we_reg;
  assign YM2151_WR_CMD = ym_wr_cmd_reg;
  assign YM2151_DIN    = ym_din_reg;
  assign OKI_WE        = oki_we_reg;
  assign OKI_DIN       = oki_din_reg;

endmodule

// File: tb/tb_truxton2_snd_writer.sv
// Self-checking bench for truxton2_snd_writer: directed scenarios plus randomized
// queue contents checked against an access-level model of order and timing.
module tb_truxton2_snd_writer;

  localparam int DEPTH   = 8;
  localparam int YM_LEN  = 4;
  localparam int OKI_LEN = 128;
  localparam int REC     = 2;
  localparam int GUARD   = 64;
  localparam int TMO_CYC = 16384;

  logic       CLK96;
  logic       RESET96_N;
  logic       PAUSE_N;
  logic       CPU_WR;
  logic       CPU_TGT;
  logic       CPU_A0;
  logic [7:0] CPU_DIN;
  logic       CPU_FULL;
  logic       YM2151_CS;
  logic       YM2151_WE;
  logic       YM2151_WR_CMD;
  logic [7:0] YM2151_DIN;
  logic [7:0] YM2151_DOUT;
  logic       OKI_WE;
  logic [7:0] OKI_DIN;
  logic       BUSY;
  logic       OVF;
  logic       TMO;

  truxton2_snd_writer dut (
    .CLK96(CLK96), .RESET96_N(RESET96_N), .PAUSE_N(PAUSE_N),
    .CPU_WR(CPU_WR), .CPU_TGT(CPU_TGT), .CPU_A0(CPU_A0), .CPU_DIN(CPU_DIN),
    .CPU_FULL(CPU_FULL), .YM2151_CS(YM2151_CS), .YM2151_WE(YM2151_WE),
    .YM2151_WR_CMD(YM2151_WR_CMD), .YM2151_DIN(YM2151_DIN), .YM2151_DOUT(YM2151_DOUT),
    .OKI_WE(OKI_WE), .OKI_DIN(OKI_DIN), .BUSY(BUSY), .OVF(OVF), .TMO(TMO)
  );

  typedef struct {
    bit       tgt;
    bit       a0;
    bit [7:0] data;
    int       len;
    int       start;
    bit       bad;
  } acc_t;

  typedef struct {
    bit       tgt;
    bit       a0;
    bit [7:0] data;
  } ent_t;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   cs_fall  = -1;
  bit   ym_cs_seen = 0;
  acc_t obs[$];
  ent_t exp_q[$];

  initial begin
    CLK96 = 1'b0;
    forever #5 CLK96 = ~CLK96;
  end

  initial forever begin
    @(posedge CLK96);
    cyc++;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Access-level monitor: one record per write strobe, with length and start cycle.
  initial begin : monitor
    int   ym_len;
    int   oki_len;
    acc_t ym_a;
    acc_t oki_a;
    logic cs_prev;
    ym_len = 0; oki_len = 0; cs_prev = 1'b0;
    ym_a = '{default: 0};
    oki_a = '{default: 0};
    forever begin
      @(negedge CLK96);
      if (RESET96_N !== 1'b1) begin
        ym_len = 0; oki_len = 0; cs_prev = 1'b0;
      end else begin
        if (YM2151_WE === 1'b0) begin
          if (ym_len == 0) begin
            ym_a.tgt = 1'b0; ym_a.a0 = YM2151_WR_CMD; ym_a.data = YM2151_DIN;
            ym_a.start = cyc; ym_a.bad = 1'b0;
          end
          if (YM2151_CS !== 1'b1 || YM2151_DIN !== ym_a.data || YM2151_WR_CMD !== ym_a.a0)
            ym_a.bad = 1'b1;
          ym_len++;
        end else if (ym_len != 0) begin
          ym_a.len = ym_len;
          obs.push_back(ym_a);
          ym_len = 0;
        end
        if (OKI_WE === 1'b0) begin
          if (oki_len == 0) begin
            oki_a.tgt = 1'b1; oki_a.a0 = 1'b0; oki_a.data = OKI_DIN;
            oki_a.start = cyc; oki_a.bad = 1'b0;
          end
          if (YM2151_CS !== 1'b0 || OKI_DIN !== oki_a.data)
            oki_a.bad = 1'b1;
          oki_len++;
        end else if (oki_len != 0) begin
          oki_a.len = oki_len;
          obs.push_back(oki_a);
          oki_len = 0;
        end
        if (YM2151_CS === 1'b1) ym_cs_seen = 1'b1;
        if (cs_prev === 1'b1 && YM2151_CS === 1'b0) cs_fall = cyc;
        cs_prev = YM2151_CS;
      end
    end
  end

  function automatic int occ(input ent_t e);
    if (e.tgt) return 1 + OKI_LEN + REC;
    if (e.a0)  return 1 + YM_LEN + REC + GUARD + 1;
    return 1 + YM_LEN + REC;
  endfunction

  function automatic int slen(input ent_t e);
    return e.tgt ? OKI_LEN : YM_LEN;
  endfunction

  task automatic do_reset;
    RESET96_N = 1'b0;
    CPU_WR = 1'b0;
    repeat (3) @(negedge CLK96);
    RESET96_N = 1'b1;
    obs.delete();
    cs_fall = -1;
    ym_cs_seen = 1'b0;
    @(negedge CLK96);
  endtask

  task automatic push(input bit tgt, input bit a0, input bit [7:0] d, output int e0);
    @(negedge CLK96);
    CPU_WR = 1'b1; CPU_TGT = tgt; CPU_A0 = a0; CPU_DIN = d;
    @(posedge CLK96);
    #1;
    e0 = cyc;
    CPU_WR = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge CLK96);
  endtask

  task automatic wait_idle(input int maxc, input string name);
    int n;
    n = 0;
    @(negedge CLK96);
    while (BUSY !== 1'b0 && n < maxc) begin
      @(negedge CLK96);
      n++;
    end
    checks++;
    if (BUSY !== 1'b0) begin
      failures++;
      $display("FAIL %s_drain: BUSY=%b after %0d cycles, required 0", name, BUSY, maxc);
    end
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if ({YM2151_CS, YM2151_WE, YM2151_WR_CMD, YM2151_DIN} !== {1'b0, 1'b1, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL reset_ym: cs/we/cmd/din=%b/%b/%b/%h required 0/1/0/00",
               YM2151_CS, YM2151_WE, YM2151_WR_CMD, YM2151_DIN);
    end
    checks++;
    if ({OKI_WE, OKI_DIN} !== {1'b1, 8'h00}) begin
      failures++;
      $display("FAIL reset_oki: we/din=%b/%h required 1/00", OKI_WE, OKI_DIN);
    end
    checks++;
    if ({CPU_FULL, BUSY, OVF, TMO} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags: full/busy/ovf/tmo=%b required 0000", {CPU_FULL, BUSY, OVF, TMO});
    end
    repeat (10) @(negedge CLK96);
    checks++;
    if (obs.size() != 0 || BUSY !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: accesses=%0d busy=%b required 0/0", obs.size(), BUSY);
    end
  endtask

  task automatic test_ym_addr;
    int e0;
    do_reset();
    PAUSE_N = 1'b1; YM2151_DOUT = 8'h00;
    push(1'b0, 1'b0, 8'h20, e0);
    wait_until(e0 + 7);
    checks++;
    if (BUSY !== 1'b1) begin
      failures++;
      $display("FAIL ym_addr_busy_mid: BUSY=%b required 1", BUSY);
    end
    wait_until(e0 + 9);
    checks++;
    if (BUSY !== 1'b0) begin
      failures++;
      $display("FAIL ym_addr_busy_end: BUSY=%b at E9 required 0", BUSY);
    end
    checks++;
    if (obs.size() != 1) begin
      failures++;
      $display("FAIL ym_addr_count: accesses=%0d required 1", obs.size());
    end else begin
      checks++;
      if (obs[0].tgt !== 1'b0 || obs[0].a0 !== 1'b0 || obs[0].data !== 8'h20 || obs[0].bad) begin
        failures++;
        $display("FAIL ym_addr_fields: tgt=%b a0=%b data=%h unstable=%b required 0/0/20/0",
                 obs[0].tgt, obs[0].a0, obs[0].data, obs[0].bad);
      end
      checks++;
      if (obs[0].start != e0 + 2 || obs[0].len != YM_LEN) begin
        failures++;
        $display("FAIL ym_addr_strobe: start=E%0d len=%0d required E2 len %0d",
                 obs[0].start - e0, obs[0].len, YM_LEN);
      end
      checks++;
      if (cs_fall != obs[0].start + obs[0].len + REC) begin
        failures++;
        $display("FAIL ym_addr_cs_fall: cs fell at E%0d required E%0d",
                 cs_fall - e0, obs[0].start + obs[0].len + REC - e0);
      end
    end
  endtask

  task automatic test_ym_data_busy;
    int e0;
    do_reset();
    PAUSE_N = 1'b1; YM2151_DOUT = 8'h80;
    push(1'b0, 1'b1, 8'h7F, e0);
    wait_until(e0 + 71);
    checks++;
    if (BUSY !== 1'b1) begin
      failures++;
      $display("FAIL ym_data_guard: BUSY=%b during guard required 1", BUSY);
    end
    wait_until(e0 + 171);
    checks++;
    if (BUSY !== 1'b1) begin
      failures++;
      $display("FAIL ym_data_poll: BUSY=%b in 100th poll cycle required 1", BUSY);
    end
    YM2151_DOUT = 8'h00;
    wait_until(e0 + 172);
    checks++;
    if (BUSY !== 1'b0 || TMO !== 1'b0) begin
      failures++;
      $display("FAIL ym_data_end: busy/tmo=%b/%b after 100 poll cycles required 0/0", BUSY, TMO);
    end
    checks++;
    if (obs.size() != 1 || obs[0].a0 !== 1'b1 || obs[0].data !== 8'h7F || obs[0].len != YM_LEN) begin
      failures++;
      $display("FAIL ym_data_access: accesses=%0d required one a0=1 data=7f write", obs.size());
    end
  endtask

  task automatic test_busy_stuck;
    int e0, e1, tend;
    do_reset();
    PAUSE_N = 1'b1; YM2151_DOUT = 8'h80;
    push(1'b0, 1'b1, 8'h55, e0);
    push(1'b0, 1'b0, 8'h33, e1);
    tend = e0 + 72 + TMO_CYC;
    wait_until(tend - 1);
    checks++;
    if (TMO !== 1'b0 || BUSY !== 1'b1) begin
      failures++;
      $display("FAIL stuck_before: tmo/busy=%b/%b one cycle before timeout required 0/1", TMO, BUSY);
    end
    wait_until(tend);
    checks++;
    if (TMO !== 1'b1) begin
      failures++;
      $display("FAIL stuck_tmo: TMO=%b after %0d poll cycles required 1", TMO, TMO_CYC);
    end
    wait_until(tend + 12);
    checks++;
    if (obs.size() != 2) begin
      failures++;
      $display("FAIL stuck_next_count: accesses=%0d required 2", obs.size());
    end else begin
      checks++;
      if (obs[1].start != tend + 2 || obs[1].data !== 8'h33 || obs[1].a0 !== 1'b0 || obs[1].len != YM_LEN) begin
        failures++;
        $display("FAIL stuck_next: start offset=%0d data=%h a0=%b len=%0d required 2/33/0/%0d",
                 obs[1].start - tend, obs[1].data, obs[1].a0, obs[1].len, YM_LEN);
      end
    end
    checks++;
    if (BUSY !== 1'b0 || TMO !== 1'b1) begin
      failures++;
      $display("FAIL stuck_final: busy/tmo=%b/%b required 0/1", BUSY, TMO);
    end
    YM2151_DOUT = 8'h00;
  endtask

  task automatic test_oki;
    int e0;
    do_reset();
    PAUSE_N = 1'b1; YM2151_DOUT = 8'h00;
    push(1'b1, 1'b0, 8'h81, e0);
    wait_until(e0 + 131);
    checks++;
    if (BUSY !== 1'b1) begin
      failures++;
      $display("FAIL oki_busy_mid: BUSY=%b required 1", BUSY);
    end
    wait_until(e0 + 132);
    checks++;
    if (BUSY !== 1'b0) begin
      failures++;
      $display("FAIL oki_busy_end: BUSY=%b required 0", BUSY);
    end
    checks++;
    if (obs.size() != 1 || obs[0].tgt !== 1'b1 || obs[0].data !== 8'h81 || obs[0].len != OKI_LEN ||
        obs[0].start != e0 + 2 || obs[0].bad) begin
      failures++;
      $display("FAIL oki_access: accesses=%0d required one 128-cycle write of 81 at E2", obs.size());
    end
    checks++;
    if (ym_cs_seen) begin
      failures++;
      $display("FAIL oki_ym_cs: YM2151_CS=1 seen required 0 throughout");
    end
  endtask

  task automatic test_overflow;
    int   e0, r, mcount, nmin;
    bit   movf;
    ent_t e;
    do_reset();
    PAUSE_N = 1'b0; YM2151_DOUT = 8'h00;
    exp_q.delete();
    mcount = 0; movf = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      e.tgt = ($urandom_range(0, 3) == 0);
      e.a0 = 1'($urandom_range(0, 1));
      e.data = 8'($urandom);
      push(e.tgt, e.a0, e.data, e0);
      if (mcount < DEPTH) begin
        exp_q.push_back(e);
        mcount++;
      end else begin
        movf = 1'b1;
      end
      repeat (2) @(negedge CLK96);
      checks++;
      if (CPU_FULL !== (mcount == DEPTH) || OVF !== movf) begin
        failures++;
        $display("FAIL ovf_push%0d: full/ovf=%b/%b required %b/%b",
                 i + 1, CPU_FULL, OVF, (mcount == DEPTH), movf);
      end
    end
    checks++;
    if (obs.size() != 0 || BUSY !== 1'b1) begin
      failures++;
      $display("FAIL ovf_paused: accesses=%0d busy=%b required 0/1", obs.size(), BUSY);
    end
    PAUSE_N = 1'b1;
    r = cyc;
    wait_idle(3000, "ovf");
    checks++;
    if (obs.size() != exp_q.size()) begin
      failures++;
      $display("FAIL ovf_count: accesses=%0d required %0d", obs.size(), exp_q.size());
    end
    nmin = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
    for (int i = 0; i < nmin; i++) begin
      checks++;
      if (obs[i].tgt !== exp_q[i].tgt || obs[i].data !== exp_q[i].data ||
          (!exp_q[i].tgt && obs[i].a0 !== exp_q[i].a0) || obs[i].len != slen(exp_q[i])) begin
        failures++;
        $display("FAIL ovf_order%0d: tgt/a0/data/len=%b/%b/%h/%0d required %b/%b/%h/%0d", i,
                 obs[i].tgt, obs[i].a0, obs[i].data, obs[i].len,
                 exp_q[i].tgt, exp_q[i].a0, exp_q[i].data, slen(exp_q[i]));
      end
    end
    if (nmin > 0) begin
      checks++;
      if (obs[0].start != r + 2) begin
        failures++;
        $display("FAIL ovf_first_start: start=%0d required %0d", obs[0].start, r + 2);
      end
    end
    checks++;
    if (CPU_FULL !== 1'b0 || OVF !== 1'b1) begin
      failures++;
      $display("FAIL ovf_after: full/ovf=%b/%b required 0/1", CPU_FULL, OVF);
    end
  endtask

  task automatic test_reset_mid_strobe;
    int e0, e1, e2;
    do_reset();
    PAUSE_N = 1'b1; YM2151_DOUT = 8'h00;
    push(1'b1, 1'b0, 8'hA5, e0);
    push(1'b0, 1'b0, 8'h11, e1);
    push(1'b0, 1'b1, 8'h22, e2);
    wait_until(e0 + 50);
    checks++;
    if (OKI_WE !== 1'b0 || OKI_DIN !== 8'hA5) begin
      failures++;
      $display("FAIL rst_mid_pre: oki we/din=%b/%h required 0/a5", OKI_WE, OKI_DIN);
    end
    #2;
    RESET96_N = 1'b0;
    #1;
    checks++;
    if (OKI_WE !== 1'b1 || OKI_DIN !== 8'h00) begin
      failures++;
      $display("FAIL rst_mid_oki: we/din=%b/%h immediately after reset required 1/00", OKI_WE, OKI_DIN);
    end
    checks++;
    if ({YM2151_CS, YM2151_WE, YM2151_WR_CMD, YM2151_DIN, CPU_FULL, BUSY, OVF, TMO} !==
        {1'b0, 1'b1, 1'b0, 8'h00, 4'b0000}) begin
      failures++;
      $display("FAIL rst_mid_outs: cs/we/cmd/din=%b/%b/%b/%h flags=%b required 0/1/0/00 0000",
               YM2151_CS, YM2151_WE, YM2151_WR_CMD, YM2151_DIN, {CPU_FULL, BUSY, OVF, TMO});
    end
    repeat (2) @(negedge CLK96);
    RESET96_N = 1'b1;
    obs.delete();
    repeat (20) @(negedge CLK96);
    checks++;
    if (obs.size() != 0 || BUSY !== 1'b0 || YM2151_WE !== 1'b1 || OKI_WE !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_empty: accesses=%0d busy=%b after release required 0/0", obs.size(), BUSY);
    end
  endtask

  task automatic test_random;
    int   e0, r, n, mcount, nmin, exp_start;
    bit   movf;
    ent_t e;
    do_reset();
    YM2151_DOUT = 8'h00;
    movf = 1'b0;
    for (int round = 0; round < 4; round++) begin
      PAUSE_N = 1'b0;
      exp_q.delete();
      obs.delete();
      mcount = 0;
      n = $urandom_range(1, DEPTH + 2);
      for (int i = 0; i < n; i++) begin
        e.tgt = ($urandom_range(0, 3) == 0);
        e.a0 = 1'($urandom_range(0, 1));
        e.data = 8'($urandom);
        push(e.tgt, e.a0, e.data, e0);
        if (mcount < DEPTH) begin
          exp_q.push_back(e);
          mcount++;
        end else begin
          movf = 1'b1;
        end
      end
      @(negedge CLK96);
      checks++;
      if (OVF !== movf) begin
        failures++;
        $display("FAIL rnd%0d_ovf: OVF=%b required %b (pushes=%0d)", round, OVF, movf, n);
      end
      PAUSE_N = 1'b1;
      r = cyc;
      wait_idle(3000, "rnd");
      checks++;
      if (obs.size() != exp_q.size()) begin
        failures++;
        $display("FAIL rnd%0d_count: accesses=%0d required %0d", round, obs.size(), exp_q.size());
      end
      nmin = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
      exp_start = r + 2;
      for (int i = 0; i < nmin; i++) begin
        checks++;
        if (obs[i].tgt !== exp_q[i].tgt || obs[i].data !== exp_q[i].data ||
            (!exp_q[i].tgt && obs[i].a0 !== exp_q[i].a0) || obs[i].bad) begin
          failures++;
          $display("FAIL rnd%0d_entry%0d: tgt/a0/data=%b/%b/%h required %b/%b/%h", round, i,
                   obs[i].tgt, obs[i].a0, obs[i].data, exp_q[i].tgt, exp_q[i].a0, exp_q[i].data);
        end
        checks++;
        if (obs[i].len != slen(exp_q[i]) || obs[i].start != exp_start) begin
          failures++;
          $display("FAIL rnd%0d_timing%0d: start=%0d len=%0d required %0d/%0d", round, i,
                   obs[i].start, obs[i].len, exp_start, slen(exp_q[i]));
        end
        exp_start = exp_start + occ(exp_q[i]) + 1;
      end
    end
  endtask

  initial begin
    RESET96_N = 1'b0;
    PAUSE_N = 1'b1;
    CPU_WR = 1'b0;
    CPU_TGT = 1'b0;
    CPU_A0 = 1'b0;
    CPU_DIN = 8'h00;
    YM2151_DOUT = 8'h00;
    test_reset();
    test_ym_addr();
    test_ym_data_busy();
    test_busy_stuck();
    test_oki();
    test_overflow();
    test_reset_mid_strobe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
